// File: rtl/rom_ddr_bridge_if.sv
// Bus bundle for rom_ddr_bridge: the toggle-handshake ROM port (loader
// writes, CPU 64-bit fetches) plus the single-beat DDR3 Avalon master.
// slave  : the bridge (responds on the ROM port, drives the Avalon commands)
// master : the environment (requesters and the DDR memory)
interface rom_ddr_bridge_if #(
  parameter int ADDR_W = 25
);
  logic [ADDR_W-1:0] wraddr;
  logic [15:0]       din;
  logic              we_req;
  logic              we_ack;
  logic [ADDR_W-1:0] rdaddr;
  logic [63:0]       dout;
  logic              rd_req;
  logic              rd_ack;

  logic              DDRAM_BUSY;
  logic [7:0]        DDRAM_BURSTCNT;
  logic [28:0]       DDRAM_ADDR;
  logic              DDRAM_RD;
  logic [63:0]       DDRAM_DIN;
  logic [7:0]        DDRAM_BE;
  logic              DDRAM_WE;
  logic [63:0]       DDRAM_DOUT;
  logic              DDRAM_DOUT_READY;

  modport slave (
    input  wraddr, din, we_req, rdaddr, rd_req,
           DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output we_ack, dout, rd_ack,
           DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );

  modport master (
    output wraddr, din, we_req, rdaddr, rd_req,
           DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  we_ack, dout, rd_ack,
           DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );
endinterface

// File: rtl/rom_ddr_bridge.sv
// rom_ddr_bridge: responder end of the toggle-handshake ROM port. Each
// pending write (16-bit) or read (64-bit) becomes one single-beat command on
// the DDR3 Avalon master; only one command is ever outstanding.
// Optional: define ROM_DDR_RDCACHE_EN for a one-entry read cache that serves
// repeated fetches of the last word without touching DDR.
module rom_ddr_bridge #(
  parameter logic [28:0] BASE_ADDR = 29'h0600000,
  parameter int          ADDR_W    = 25
) (
  input  logic           DDRAM_CLK,
  input  logic           reset,
  rom_ddr_bridge_if.slave bus
);

  localparam int TAG_W = ADDR_W - 3;

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

  state_t      state_q;
  logic        we_ack_q, rd_ack_q;
  logic        ddr_rd_q, ddr_we_q;
  logic [7:0]  be_q;
  logic [28:0] addr_q;
  logic [63:0] din_q, dout_q;
  // Survives reset on purpose: a read abandoned by reset still has its data
  // beat coming back, and that beat must not be mistaken for a new read.
  logic        rd_inflight_q = 1'b0;

  logic [TAG_W-1:0] wr_tag, rd_tag;
  logic             wr_pend, rd_pend, rd_hit, accept;
  logic             unused_addr_bits;

  assign wr_tag  = bus.wraddr[ADDR_W-1:3];
  assign rd_tag  = bus.rdaddr[ADDR_W-1:3];
  assign wr_pend = bus.we_req != we_ack_q;
  assign rd_pend = bus.rd_req != rd_ack_q;
  assign accept  = !bus.DDRAM_BUSY;
  assign unused_addr_bits = ^{bus.wraddr[0], bus.rdaddr[2:0]};

  function automatic logic [28:0] word_addr(input logic [TAG_W-1:0] t);
    return BASE_ADDR + 29'(t);
  endfunction

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

`ifdef ROM_DDR_RDCACHE_EN
  logic [TAG_W-1:0] tag_q, req_tag_q;
  logic             cval_q;
  assign rd_hit = cval_q && (rd_tag == tag_q);
`else
  assign rd_hit = 1'b0;
`endif

  // Command FSM: arbitration in IDLE (write first), Avalon hold/accept, ack toggles
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      ddr_rd_q <= 1'b0;
      ddr_we_q <= 1'b0;
      be_q     <= 8'hFF;
      addr_q   <= BASE_ADDR;
      din_q    <= '0;
      dout_q   <= '0;
      we_ack_q <= bus.we_req;
      rd_ack_q <= bus.rd_req;
`ifdef ROM_DDR_RDCACHE_EN
      cval_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_pend) begin
            ddr_we_q <= 1'b1;
            addr_q   <= word_addr(wr_tag);
            din_q    <= {4{bus.din}};
            be_q     <= 8'b11 << {bus.wraddr[2:1], 1'b0};
            state_q  <= WR;
`ifdef ROM_DDR_RDCACHE_EN
            req_tag_q <= wr_tag;
`endif
          end else if (rd_pend && rd_hit) begin
            rd_ack_q <= ~rd_ack_q;
          end else if (rd_pend && !rd_inflight_q) begin
            ddr_rd_q <= 1'b1;
            addr_q   <= word_addr(rd_tag);
            be_q     <= 8'hFF;
            state_q  <= RD;
`ifdef ROM_DDR_RDCACHE_EN
            req_tag_q <= rd_tag;
`endif
          end
        end
        WR: begin
          if (accept) begin
            ddr_we_q <= 1'b0;
            we_ack_q <= ~we_ack_q;
            state_q  <= IDLE;
`ifdef ROM_DDR_RDCACHE_EN
            // keep the cached word coherent with the lane just written
            if (cval_q && req_tag_q == tag_q)
              dout_q <= (dout_q & ~be_mask(be_q)) | (din_q & be_mask(be_q));
`endif
          end
        end
        RD: begin
          if (accept) begin
            ddr_rd_q <= 1'b0;
            state_q  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.DDRAM_DOUT_READY) begin
            dout_q   <= bus.DDRAM_DOUT;
            rd_ack_q <= ~rd_ack_q;
            state_q  <= IDLE;
`ifdef ROM_DDR_RDCACHE_EN
            tag_q    <= req_tag_q;
            cval_q   <= 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Track a read whose data beat is still owed by DDR after reset cut it off
  always_ff @(posedge DDRAM_CLK) begin
    if (reset && ((state_q == RD_WAIT && !bus.DDRAM_DOUT_READY) ||
                  (state_q == RD && accept)))
      rd_inflight_q <= 1'b1;
    else if (bus.DDRAM_DOUT_READY)
      rd_inflight_q <= 1'b0;
  end

  assign bus.we_ack         = we_ack_q;
  assign bus.rd_ack         = rd_ack_q;
  assign bus.dout           = dout_q;
  assign bus.DDRAM_BURSTCNT = 8'd1;
  assign bus.DDRAM_ADDR     = addr_q;
  assign bus.DDRAM_RD       = ddr_rd_q;
  assign bus.DDRAM_WE       = ddr_we_q;
  assign bus.DDRAM_DIN      = din_q;
  assign bus.DDRAM_BE       = be_q;

endmodule

// File: tb/tb_rom_ddr_bridge.sv
// Bench for rom_ddr_bridge: directed scenarios plus a randomized mix of
// writes/reads against a 16-bit-lane reference memory and a behavioural
// DDR model with random waitrequest and read latency.
`timescale 1ns/1ps
module tb_rom_ddr_bridge;
  localparam int          ADDR_W = 25;
  localparam logic [28:0] BASE   = 29'h0600000;

  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  rom_ddr_bridge_if #(.ADDR_W(ADDR_W)) bus ();
  rom_ddr_bridge_if #(.ADDR_W(ADDR_W)) wbus ();

  rom_ddr_bridge #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W)) dut (
    .DDRAM_CLK(clk), .reset(rst), .bus(bus));
  rom_ddr_bridge #(.BASE_ADDR(29'h1FFFFFFF), .ADDR_W(ADDR_W)) dut_w (
    .DDRAM_CLK(clk), .reset(rst), .bus(wbus));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- reference: 16-bit lanes keyed by byte_addr>>1 ----------
  logic [15:0] ref16 [int];

  function automatic logic [63:0] ref_word(input int w);
    logic [63:0] r;
    for (int k = 0; k < 4; k++)
      r[16*k +: 16] = ref16.exists(w*4+k) ? ref16[w*4+k] : 16'h0;
    return r;
  endfunction

  // ---------------- DDR model ----------------
  logic [63:0] mem [logic [28:0]];
  int busy_pct = 0, lat_lo = 1, lat_hi = 1;
  logic hold_on = 1'b0;
  int hold_until = 0;
  int force_seq = -1;
  logic [63:0] force_val = '0;

  // written only by the posedge monitor
  int rd_cnt = 0, wr_cnt = 0, we_hi = 0, rd_hi_busy = 0, rd_bad = 0;
  logic rd_active = 1'b0, dr_last = 1'b0;
  logic [28:0] rd_first, rd_acc;
  logic [28:0] wr_addr_l;
  logic [7:0]  wr_be_l;
  logic [63:0] wr_din_l;
  byte cmd_log [$];

  // written only by the negedge responder
  int rd_seen = 0, resp_cnt = 0, rd_cnt_at_stray = -1;

  always @(posedge clk) begin
    dr_last = bus.DDRAM_DOUT_READY;
    if (bus.DDRAM_WE) begin
      we_hi++;
      if (!bus.DDRAM_BUSY) begin
        logic [63:0] w;
        wr_cnt++;
        cmd_log.push_back("W");
        wr_addr_l = bus.DDRAM_ADDR;
        wr_be_l   = bus.DDRAM_BE;
        wr_din_l  = bus.DDRAM_DIN;
        w = mem.exists(bus.DDRAM_ADDR) ? mem[bus.DDRAM_ADDR] : 64'h0;
        for (int b = 0; b < 8; b++)
          if (bus.DDRAM_BE[b]) w[8*b +: 8] = bus.DDRAM_DIN[8*b +: 8];
        mem[bus.DDRAM_ADDR] = w;
      end
    end
    if (bus.DDRAM_RD) begin
      if (!rd_active) begin
        rd_active = 1'b1;
        rd_first  = bus.DDRAM_ADDR;
      end else if (bus.DDRAM_ADDR !== rd_first) rd_bad++;
      if (bus.DDRAM_BUSY) rd_hi_busy++;
      else begin
        rd_cnt++;
        cmd_log.push_back("R");
        rd_active = 1'b0;
        rd_acc    = bus.DDRAM_ADDR;
      end
    end
  end

  always @(negedge clk) begin
    bus.DDRAM_DOUT_READY = 1'b0;
    bus.DDRAM_BUSY = hold_on ? (rd_hi_busy < hold_until)
                             : ($urandom_range(99, 0) < busy_pct);
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        bus.DDRAM_DOUT_READY = 1'b1;
        if (rd_seen == force_seq) begin
          bus.DDRAM_DOUT  = force_val;
          rd_cnt_at_stray = rd_cnt;
        end else
          bus.DDRAM_DOUT = mem.exists(rd_acc) ? mem[rd_acc] : 64'h0;
      end
    end else if (rd_cnt != rd_seen) begin
      rd_seen  = rd_cnt;
      resp_cnt = $urandom_range(lat_hi, lat_lo);
    end
  end

  // ---------------- request tasks ----------------
  task automatic do_wr(input logic [24:0] a, input logic [15:0] d, output int lat);
    logic a0;
    a0 = bus.we_ack;
    bus.wraddr = a; bus.din = d; bus.we_req = ~bus.we_req;
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.we_ack !== a0) begin lat = i; break; end
    end
    if (lat < 0) chk("wr_timeout", 0, 1);
    ref16[int'(a >> 1)] = d;
  endtask

  task automatic do_rd(input logic [24:0] a, output int lat);
    logic a0;
    a0 = bus.rd_ack;
    bus.rdaddr = a; bus.rd_req = ~bus.rd_req;
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.rd_ack !== a0) begin lat = i; break; end
    end
    if (lat < 0) chk("rd_timeout", 0, 1);
  endtask

  task automatic chk_wr(input string tag, input logic [24:0] a, input logic [15:0] d);
    logic [7:0] eb;
    eb = 8'h03 << (2 * int'(a[2:1]));
    chk({tag, "_addr"}, 64'(wr_addr_l), 64'(BASE + 29'(a >> 3)));
    chk({tag, "_be"},   64'(wr_be_l), 64'(eb));
    chk({tag, "_din"},  wr_din_l, {4{d}});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c0, c1, wl, rl;
    logic [24:0] a;
    logic [15:0] d;
    logic [63:0] w;

    rst = 1'b1;
    bus.wraddr = '0; bus.din = '0; bus.we_req = 1'b0;
    bus.rdaddr = '0; bus.rd_req = 1'b1;
    bus.DDRAM_DOUT = '0;
    wbus.wraddr = '0; wbus.din = '0; wbus.we_req = 1'b0;
    wbus.rdaddr = '0; wbus.rd_req = 1'b0;
    wbus.DDRAM_BUSY = 1'b0; wbus.DDRAM_DOUT = '0; wbus.DDRAM_DOUT_READY = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state (rd_req was 1 during reset: must be absorbed, not served)
    chk("rst_rd",    64'(bus.DDRAM_RD), 0);
    chk("rst_we",    64'(bus.DDRAM_WE), 0);
    chk("rst_be",    64'(bus.DDRAM_BE), 64'hFF);
    chk("rst_addr",  64'(bus.DDRAM_ADDR), 64'(BASE));
    chk("rst_din",   bus.DDRAM_DIN, 0);
    chk("rst_dout",  bus.dout, 0);
    chk("rst_burst", 64'(bus.DDRAM_BURSTCNT), 1);
    chk("rst_rdack", 64'(bus.rd_ack), 1);
    chk("rst_weack", 64'(bus.we_ack), 0);
    chk("rst_waddr", 64'(wbus.DDRAM_ADDR), 64'h1FFFFFFF);
    repeat (3) @(negedge clk);
    chk("rst_norq",  64'(rd_cnt), 0);

    // single write, no waitrequest
    c0 = we_hi;
    do_wr(25'h000006, 16'hBEEF, lat);
    chk("wr_lat",  64'(lat), 2);
    chk("wr_hi",   64'(we_hi - c0), 1);
    chk_wr("wr", 25'h000006, 16'hBEEF);
    chk("wr_be_c0", 64'(wr_be_l), 64'hC0);

    // read held by waitrequest for 5 cycles
    force_seq = rd_cnt + 1; force_val = 64'h0123456789ABCDEF;
    lat_lo = 3; lat_hi = 3;
    hold_until = rd_hi_busy + 5; hold_on = 1'b1;
    c0 = rd_cnt; c1 = rd_bad;
    do_rd(25'h000010, lat);
    hold_on = 1'b0;
    chk("hold_cycles", 64'(rd_hi_busy - hold_until + 5), 5);
    chk("hold_stable", 64'(rd_bad - c1), 0);
    chk("hold_addr",   64'(rd_acc), 64'(BASE + 29'd2));
    chk("hold_accept", 64'(rd_cnt - c0), 1);
    chk("hold_dout",   bus.dout, 64'h0123456789ABCDEF);
    chk("hold_ackbeat", 64'(dr_last), 1);

    // simultaneous write and read: write wins arbitration
    lat_lo = 1; lat_hi = 2;
    cmd_log.delete();
    a = bus.we_ack; d = {15'h0, bus.rd_ack};
    bus.wraddr = 25'h000040; bus.din = 16'hA5A5; bus.we_req = ~bus.we_req;
    bus.rdaddr = 25'h000040; bus.rd_req = ~bus.rd_req;
    ref16[int'(25'h40 >> 1)] = 16'hA5A5;
    wl = -1; rl = -1;
    for (int i = 1; i <= 300 && (wl < 0 || rl < 0); i++) begin
      @(negedge clk);
      if (wl < 0 && bus.we_ack !== a[0]) wl = i;
      if (rl < 0 && bus.rd_ack !== d[0]) rl = i;
    end
    chk("sim_both",   64'(wl > 0 && rl > 0), 1);
    chk("sim_order",  64'(wl < rl), 1);
    chk("sim_ncmd",   64'(cmd_log.size()), 2);
    if (cmd_log.size() == 2) begin
      chk("sim_cmd0", 64'(cmd_log[0]), 64'("W"));
      chk("sim_cmd1", 64'(cmd_log[1]), 64'("R"));
    end
    chk("sim_dout", bus.dout, ref_word(25'h40 >> 3));

    // reset while waiting for read data: stray beat must be swallowed
    do_wr(25'h000018, 16'h1234, lat);
    force_seq = rd_cnt + 1; force_val = 64'hDEAD;
    lat_lo = 8; lat_hi = 8;
    c0 = rd_cnt;
    bus.rdaddr = 25'h000018; bus.rd_req = ~bus.rd_req;
    for (int i = 0; i < 300 && rd_cnt == c0; i++) @(negedge clk);
    chk("rw_issued", 64'(rd_cnt - c0), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw_discard", 64'(bus.rd_ack), 64'(bus.rd_req));
    lat_lo = 2; lat_hi = 2;
    c0 = rd_cnt;
    do_rd(25'h000018, lat);
    chk("rw_noearly", 64'(rd_cnt_at_stray), 64'(c0));
    chk("rw_onerd",   64'(rd_cnt - c0), 1);
    chk("rw_dout",    bus.dout, 64'h1234);
    c0 = wr_cnt;
    do_wr(25'h00001A, 16'h7777, lat);
    chk("rw_wr_ok",   64'(wr_cnt - c0), 1);

    // address wrap on the second instance
    wbus.wraddr = 25'h000008; wbus.din = 16'h4242; wbus.we_req = ~wbus.we_req;
    @(negedge clk);
    chk("wrap_we",   64'(wbus.DDRAM_WE), 1);
    chk("wrap_addr", 64'(wbus.DDRAM_ADDR), 0);
    @(negedge clk);
    chk("wrap_ack",  64'(wbus.we_ack), 64'(wbus.we_req));

    // read cache behaviour (or its absence)
    lat_lo = 1; lat_hi = 3;
    c0 = rd_cnt;
    do_rd(25'h000020, lat);
    do_rd(25'h000020, lat);
`ifdef ROM_DDR_RDCACHE_EN
    chk("c_onerd",  64'(rd_cnt - c0), 1);
    chk("c_hitlat", 64'(lat), 1);
    do_wr(25'h000022, 16'h5555, lat);
    c0 = rd_cnt;
    do_rd(25'h000020, lat);
    chk("c_nord",   64'(rd_cnt - c0), 0);
    w = bus.dout;
    chk("c_merge",  64'(w[31:16]), 64'h5555);
    chk("c_word",   w, ref_word(25'h20 >> 3));
`else
    chk("nc_tword", 64'(rd_cnt - c0), 2);
    chk("nc_dout",  bus.dout, ref_word(25'h20 >> 3));
`endif

    // randomized mix with waitrequest and variable latency
    busy_pct = 30; lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 80; n++) begin
      a = 25'h000100 + 25'($urandom_range(31, 0));
      if ($urandom_range(1, 0) == 1) begin
        d = 16'($urandom);
        do_wr(a, d, lat);
        chk_wr("rnd_wr", a, d);
      end else begin
        do_rd(a, lat);
        chk("rnd_rd", bus.dout, ref_word(int'(a >> 3)));
      end
    end
    busy_pct = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
